// File: rtl/sequenciador_quadros.sv
// Frame sequencer: walks each display frame byte by byte and picks the animation frame index.
// Optional MORTO_HOLD_EN: the MORTO animation plays once and holds its last frame.
module sequenciador_quadros #(
   parameter int FRAME_BYTES     = 1024,
   parameter int FRAMES_PER_STEP = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [4:0] estado,
   input  logic       byte_ready,
   output logic [9:0] byte_counter,
   output logic [2:0] frame_index,
   output logic [4:0] estado_frame,
   output logic       byte_valid,
   output logic       frame_start,
   output logic       frame_done,
   output logic       busy
);

   localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [SW-1:0] STEP_LAST = SW'(FRAMES_PER_STEP - 1);
   localparam logic [9:0] BYTE_LAST = 10'(FRAME_BYTES - 1);

   typedef enum logic [1:0] {
      S_WAIT,
      S_LOAD,
      S_FETCH,
      S_SEND
   } state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] step;
   logic          first;
   logic          hs, last_hs;
   logic [3:0]    size;
   logic [2:0]    idx_nxt;

   assign byte_valid  = (state == S_SEND);
   assign frame_start = (state == S_LOAD);
   assign busy        = (state != S_WAIT);
   assign hs          = byte_valid & byte_ready;
   assign last_hs     = hs & (byte_counter == BYTE_LAST);

   // Animation length per game state; anything not one-hot falls back to IDLE.
   always_comb begin
      size = 4'd6;
      case (estado_frame)
         5'b00000: size = 4'd1;
         5'b00001: size = 4'd6;
         5'b00010: size = 4'd4;
         5'b00100: size = 4'd5;
         5'b01000: size = 4'd7;
         5'b10000: size = 4'd8;
         default:  size = 4'd6;
      endcase
   end

   always_comb begin
      idx_nxt = (({1'b0, frame_index} + 4'd1) == size) ? 3'd0
                                                        : frame_index + 3'd1;
`ifdef MORTO_HOLD_EN
      if (estado_frame == 5'b10000 && frame_index == 3'd7)
         idx_nxt = 3'd7;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= S_WAIT;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_WAIT:  if (enable) state_nxt = S_LOAD;
         S_LOAD:  state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_SEND;
         S_SEND: begin
            if (last_hs)
               state_nxt = enable ? S_LOAD : S_WAIT;
            else if (hs)
               state_nxt = S_FETCH;
         end
         default: state_nxt = S_WAIT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_counter <= 10'd0;
         frame_index  <= 3'd0;
         estado_frame <= 5'd0;
         step         <= '0;
         first        <= 1'b1;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= last_hs;
         if (state == S_LOAD) begin
            estado_frame <= estado;
            first        <= 1'b0;
            if (first || estado != estado_frame) begin
               frame_index <= 3'd0;
               step        <= '0;
            end
         end
         if (hs)
            byte_counter <= last_hs ? 10'd0 : byte_counter + 10'd1;
         if (last_hs) begin
            if (step == STEP_LAST) begin
               step        <= '0;
               frame_index <= idx_nxt;
            end else begin
               step <= step + SW'(1);
            end
         end
      end
   end

endmodule

// File: doc/sequenciador_quadros.md
# sequenciador_quadros

Frame sequencer for the image pipeline. It walks the byte address 0..1023 of each 1 KiB display frame and handshakes every byte with the display driver. It also picks the animation frame index for the current game state, advancing it every `FRAMES_PER_STEP` complete frames. It sits between the game-state FSM and the image-memory/status-bar controller, whose `data_to_send` it qualifies with `byte_valid` one cycle after presenting `byte_counter`.

## Interface

Parameters:
- `FRAME_BYTES`, default 1024: bytes per display frame; must be a power of two, at most 1024.
- `FRAMES_PER_STEP`, default 8: completed display frames per animation step; must be 1 or more.

Ports:
- `clk`, input, 1: single system clock, rising-edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `enable`, input, 1: start or continue streaming frames; sampled only at frame boundaries.
- `estado`, input, 5: one-hot game state (INTRO=00000, IDLE=00001, DORMINDO=00010, COMENDO=00100, DANDO_AULA=01000, MORTO=10000).
- `byte_ready`, input, 1: display driver accepts the current byte.
- `byte_counter`, output, 10: byte address presented to the image controller.
- `frame_index`, output, 3: animation frame index presented to the image controller.
- `estado_frame`, output, 5: state latched for the frame in flight.
- `byte_valid`, output, 1: `data_to_send` is valid for the current `byte_counter`.
- `frame_start`, output, 1: one-cycle pulse at the start of each frame.
- `frame_done`, output, 1: one-cycle pulse after the last byte is accepted.
- `busy`, input/output: `busy` is an output, 1 bit, high whenever a frame is in flight.

## Operation

- FSM states and transitions:
  - WAIT: leaves for LOAD when `enable`=1.
  - LOAD: one cycle, then FETCH.
  - FETCH: one cycle, then SEND.
  - SEND: stays until the handshake.
- LOAD:
  - Latches `estado` into `estado_frame`.
  - If the latched value differs from the previous `estado_frame`, or this is the first frame after reset: `frame_index`←0, step counter←0.
  - `frame_start`=1 and `busy`=1 from LOAD through SEND.
- FETCH: `byte_valid`=0. Covers the image controller's one-cycle registered read.
- SEND: `byte_valid`=1, held until `byte_ready`=1. Outputs stay stable while stalled.
- Handshake (`byte_valid`&`byte_ready`):
  - If `byte_counter` < FRAME_BYTES-1: `byte_counter`+1, go to FETCH.
  - Otherwise: `byte_counter`←0, frame-end update, go to LOAD if `enable`=1, else WAIT.
- Frame-end update:
  - If step = FRAMES_PER_STEP-1: step←0, `frame_index`←(`frame_index`+1 == SIZE) ? 0 : `frame_index`+1.
  - Otherwise step←step+1.
- SIZE depends on `estado_frame`: INTRO 1, IDLE 6, DORMINDO 4, COMENDO 5, DANDO_AULA 7, MORTO 8. Any non-one-hot or unknown value uses SIZE 6 and `frame_index` 0..5.
- `estado` changes mid-frame are ignored until the next LOAD.
- `enable` dropping mid-frame does not abort; the frame completes.
- Step counter width is clog2(FRAMES_PER_STEP), minimum 1 bit.

## Timing

- Reset values: `byte_counter`=0, `frame_index`=0, `estado_frame`=00000, step=0, `byte_valid`=0, `frame_start`=0, `frame_done`=0, `busy`=0, FSM in WAIT.
- Reset asserted mid-frame returns everything to the reset values immediately; no partial-frame completion.
- `enable` to `frame_start`: `enable` high in WAIT gives LOAD on the next cycle.
- `byte_counter` update to `byte_valid`: exactly 1 cycle (FETCH).
- Minimum per byte: 2 cycles. Minimum frame with `byte_ready` tied high: 1 + 2·FRAME_BYTES cycles (2049).
- `frame_done`: registered pulse in the cycle after the final handshake. This is the same cycle as LOAD (back-to-back `frame_start`) or the first cycle of WAIT.
- `frame_index` and `estado_frame` change only at a final handshake or in LOAD. They are stable for all bytes of a frame.

## Configuration

- Macro `MORTO_HOLD_EN`.
  - Defined: when `estado_frame`=MORTO, the animation plays once and `frame_index` saturates at 7; it restarts at 0 only on a state change.
  - Undefined: MORTO wraps 7→0 like every other state.

## Test plan

Bench uses FRAMES_PER_STEP=2.

1. Reset, `enable`=1, `estado`=IDLE, `byte_ready`=1 → `frame_start` at cycle 1; `byte_valid` on alternate cycles; `byte_counter` runs 0..1023; `frame_done` 2049 cycles after `frame_start`.
2. IDLE for 12 frames → `frame_index` sequence per frame 0,0,1,1,2,2,3,3,4,4,5,5, then 0.
3. `byte_ready` held low 5 cycles at byte 300 → `byte_counter`=300 and `byte_valid`=1 held for all 5 cycles; no skipped or duplicated address.
4. Switch `estado` IDLE→DORMINDO at byte 500 of a frame with index 3 → the current frame finishes with `estado_frame`=IDLE, index 3; the next LOAD gives `estado_frame`=DORMINDO, `frame_index`=0.
5. `rst` pulsed at byte 700 → all outputs return to reset values in the same cycle; the next frame starts at byte 0, index 0.
6. MORTO for 20 frames → with `MORTO_HOLD_EN`, index reaches 7 at frame 15 and stays 7; without it, index reads 0 at frames 17–18.
